// File: rtl/gcd_pkg.sv
// gcd_pkg
// Shared definitions for the subtractive-Euclid GCD engine.
//   WIDTH_DEFAULT : default operand/result width in bits
//   state_e       : engine states (LOAD, CALC, DONE)
package gcd_pkg;

    localparam int WIDTH_DEFAULT = 16;

    // LOAD spends one edge settling after reset release, CALC iterates,
    // DONE holds the answer until the parent pulses reset again.
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gcd_step.sv
// gcd_step
// One combinational compare/subtract step of the subtractive Euclid algorithm.
// Ports:
//   x_i, y_i       : current operand pair
//   next_x_o       : x after this step (x-y when x>y, else unchanged)
//   next_y_o       : y after this step (y-x when y>x, else unchanged)
//   done_o         : high when the pair is terminal (a zero operand, or x==y)
//   result_o       : GCD when done_o is high; zero whenever either operand is zero
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] next_x_o,
    output logic [WIDTH-1:0] next_y_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    // Priority matters: a zero operand is checked first so that (0,0) reports
    // 0 rather than falling into the equal branch, and so that a single zero
    // never leaves the engine subtracting zero forever. The subtraction always
    // takes larger minus smaller, so it cannot wrap.
    always_comb begin
        next_x_o = x_i;
        next_y_o = y_i;
        done_o   = 1'b0;
        result_o = '0;
        if ((x_i == '0) || (y_i == '0)) begin
            done_o = 1'b1;
        end else if (x_i == y_i) begin
            done_o   = 1'b1;
            result_o = x_i;
        end else if (x_i > y_i) begin
            next_x_o = x_i - y_i;
        end else begin
            next_y_o = y_i - x_i;
        end
    end

endmodule

// File: rtl/gcd.sv
// gcd
// Sequential GCD engine. Operands are captured on every edge while rst is low;
// after release it performs one subtraction per clock and then raises rdy with
// the result on xo, holding both until the next reset.
// Ports:
//   clk : system clock, rising-edge
//   rst : synchronous active-low reset / operand load strobe
//   xi  : operand X (unsigned, sampled while rst=0)
//   yi  : operand Y (unsigned, sampled while rst=0)
//   xo  : GCD result, valid when rdy=1 (zero otherwise)
//   rdy : done flag, rises once per computation
module gcd
    import gcd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] xi,
    input  logic [WIDTH-1:0] yi,
    output logic [WIDTH-1:0] xo,
    output logic             rdy
);

    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] xo_q;
    logic             rdy_q;
    state_e           state_q;

    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] y_d;
    logic             stepDone;
    logic [WIDTH-1:0] stepResult;

    // The arithmetic lives in its own leaf so the register/FSM shell below
    // only decides when a step is committed.
    gcd_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .x_i      (x_q),
        .y_i      (y_q),
        .next_x_o (x_d),
        .next_y_o (y_d),
        .done_o   (stepDone),
        .result_o (stepResult)
    );

    // Reset doubles as the operand load: every low edge recaptures xi/yi and
    // clears the outputs, so the last low edge defines the operands and a
    // mid-run reset abandons the old computation. xo and rdy are only ever
    // written together, which keeps xo at zero while rdy is low. DONE is
    // sticky; only reset leaves it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q     <= xi;
            y_q     <= yi;
            xo_q    <= '0;
            rdy_q   <= 1'b0;
            state_q <= LOAD;
        end else begin
            case (state_q)
                LOAD: begin
                    state_q <= CALC;
                end
                CALC: begin
                    if (stepDone) begin
                        xo_q    <= stepResult;
                        rdy_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        x_q <= x_d;
                        y_q <= y_d;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    assign xo  = xo_q;
    assign rdy = rdy_q;

endmodule

// File: tb/tb_gcd.sv
// tb_gcd
// Self-checking bench for the gcd engine: a table of directed operand pairs
// with known results and latencies, a mid-run reset sequence, and random
// pairs checked against a modulo-based Euclid reference.
module tb_gcd;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] xi  = '0;
    logic [WIDTH-1:0] yi  = '0;
    logic [WIDTH-1:0] xo;
    logic             rdy;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] expQ[$];

    typedef struct {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] expGcd;
        int               expLat;
    } vec_t;

    vec_t vecs[8];

    // Free-running clock; all driving and sampling happens on the falling edge.
    always #5 clk = ~clk;

    gcd #(
        .WIDTH(WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .xi  (xi),
        .yi  (yi),
        .xo  (xo),
        .rdy (rdy)
    );

    // Independent reference: modulo Euclid, not the subtractive walk.
    function automatic int refGcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Counts subtractive steps (capped) so random pairs can be kept short.
    function automatic int subSteps(input int a, input int b, input int cap);
        int n = 0;
        while (a != 0 && b != 0 && a != b && n <= cap) begin
            if (a > b) a = a - b;
            else       b = b - a;
            n++;
        end
        return n;
    endfunction

    // Single comparison point: every check goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // Holds reset low for holdCycles edges with the operands, confirms the
    // outputs are cleared, then releases reset on a falling edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input int holdCycles);
        @(negedge clk);
        rst = 1'b0;
        xi  = x;
        yi  = y;
        repeat (holdCycles) @(negedge clk);
        checkOutput("rdy cleared in reset", {31'd0, rdy}, 32'd1 - 32'd1);
        checkOutput("xo cleared in reset", {16'd0, xo}, 32'd0);
        rst = 1'b1;
    endtask

    // Counts edges from release until rdy, bounded by budget, and compares
    // against the head of the scoreboard. expLat < 0 skips the latency check.
    task automatic waitResult(input string name, input int budget, input int expLat);
        int               edges = 0;
        bit               seen = 1'b0;
        bit               busyClean = 1'b1;
        logic [WIDTH-1:0] expVal;
        while (edges < budget) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (rdy === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (xo !== '0) busyClean = 1'b0;
        end
        expVal = (expQ.size() > 0) ? expQ.pop_front() : '0;
        checkOutput({name, " rdy within budget"}, {31'd0, seen}, 32'd1);
        checkOutput({name, " xo zero while busy"}, {31'd0, busyClean}, 32'd1);
        if (seen) begin
            checkOutput({name, " xo"}, {16'd0, xo}, {16'd0, expVal});
            if (expLat >= 0) checkOutput({name, " latency"}, edges, expLat);
        end
    endtask

    // Main sequence: directed table, mid-run reset, then random pairs.
    initial begin
        int a;
        int b;
        int tries;
        bit stable;
        bit lowSeen;

        vecs[0] = '{16'd13,    16'd7,     16'd1,     9};
        vecs[1] = '{16'd65535, 16'd65535, 16'd65535, 2};
        vecs[2] = '{16'd0,     16'd7,     16'd0,     2};
        vecs[3] = '{16'd7,     16'd0,     16'd0,     2};
        vecs[4] = '{16'd0,     16'd0,     16'd0,     2};
        vecs[5] = '{16'd42,    16'd18,    16'd6,     6};
        vecs[6] = '{16'd18,    16'd42,    16'd6,     6};
        vecs[7] = '{16'd12,    16'd8,     16'd4,     4};

        for (int i = 0; i < 8; i++) begin
            expQ.push_back(vecs[i].expGcd);
            applyStimulus(vecs[i].x, vecs[i].y, 5);
            xi = ~vecs[i].x;
            yi = vecs[i].y + 16'd3;
            waitResult($sformatf("vec%0d (%0d,%0d)", i, vecs[i].x, vecs[i].y),
                       1000, vecs[i].expLat);
            stable = 1'b1;
            for (int c = 0; c < 20; c++) begin
                xi = WIDTH'($urandom);
                yi = WIDTH'($urandom);
                @(negedge clk);
                if (rdy !== 1'b1 || xo !== vecs[i].expGcd) stable = 1'b0;
            end
            checkOutput($sformatf("vec%0d hold 20 cycles", i), {31'd0, stable}, 32'd1);
        end

        applyStimulus(16'd65535, 16'd1, 3);
        lowSeen = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (rdy !== 1'b0) lowSeen = 1'b0;
        end
        checkOutput("midrun still busy", {31'd0, lowSeen}, 32'd1);
        rst = 1'b0;
        xi  = 16'd12;
        yi  = 16'd8;
        lowSeen = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rdy !== 1'b0 || xo !== '0) lowSeen = 1'b0;
        end
        checkOutput("midrun rdy low in reset", {31'd0, lowSeen}, 32'd1);
        rst = 1'b1;
        expQ.push_back(16'd4);
        waitResult("midrun restart (12,8)", 100, 4);

        for (int r = 0; r < 100; r++) begin
            tries = 0;
            do begin
                a = $urandom_range(1, 65535);
                b = $urandom_range(1, 65535);
                tries++;
            end while (subSteps(a, b, 400) > 400 && tries < 1000);
            if (subSteps(a, b, 400) > 400) begin
                a = 1071;
                b = 462;
            end
            expQ.push_back(WIDTH'(refGcd(a, b)));
            applyStimulus(WIDTH'(a), WIDTH'(b), 1 + $urandom_range(0, 2));
            xi = WIDTH'($urandom);
            yi = WIDTH'($urandom);
            waitResult($sformatf("random%0d (%0d,%0d)", r, a, b), 65540, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gcd.md
Name: gcd

Overview:
- Sequential greatest-common-divisor engine for two unsigned WIDTH-bit operands, using the subtractive Euclid algorithm.
- While reset is asserted it captures the operands. After reset is released it iterates one subtraction per clock.
- When finished it presents the result on xo and raises rdy.
- Standalone arithmetic leaf block. A parent handshakes by pulsing reset low and waiting for the rising edge of rdy.

Parameters:
- WIDTH, 16, operand and result width in bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-low; while low, operands are loaded and outputs cleared.
- xi  input  WIDTH  operand X, unsigned; sampled on every clk edge where rst=0.
- yi  input  WIDTH  operand Y, unsigned; sampled on every clk edge where rst=0.
- xo  output  WIDTH  GCD result; valid when rdy=1.
- rdy  output  1  done flag; rises once per computation and stays high until the next reset.

Behaviour:
- One clock domain. Reset is synchronous and active-low; there is no asynchronous path.
- Internal registers: x, y (WIDTH bits each) and a state register with states LOAD, CALC, DONE.
- On any rising clk edge with rst=0:
  - x<=xi, y<=yi, xo<=0, rdy<=0, state<=LOAD.
  - The last edge with rst=0 defines the operands.
- LOAD (first edge with rst=1): state<=CALC. No arithmetic is done in this state; x and y keep the loaded values.
- CALC, evaluated each edge in this priority order:
  - x==0 or y==0: xo<=0, rdy<=1, state<=DONE. This is a decided rule: GCD with any zero operand is 0, including (0,0).
  - x==y: xo<=x, rdy<=1, state<=DONE.
  - x>y: x<=x-y.
  - otherwise: y<=y-x.
- DONE: xo and rdy hold. xi and yi are ignored. Only rst=0 leaves DONE.
- Arithmetic:
  - Unsigned compare and subtract only. Subtraction always takes the larger minus the smaller, so no wrap occurs.
  - No divider and no multiplier.
- Latency, counted from the first edge with rst=1:
  - Equal or zero operands: rdy=1 after the 2nd edge.
  - General case: 2 + N edges, where N is the number of subtraction steps.
  - Worst case (2^WIDTH-1, 1): about 2^WIDTH edges.
- xo and rdy update on the same edge; xo is never nonzero while rdy=0.
- Reset mid-operation (rst=0 in CALC): abandon the computation, reload operands, clear rdy. This guarantees a fresh rdy rising edge.
- Operand changes while rst=1 have no effect.
- Outputs are registered; there is no combinational input-to-output path.

Decomposition:
- Package gcd_pkg:
  - WIDTH default constant, 16.
  - State enum typedef: LOAD, CALC, DONE.
- Sub-module gcd_step: purely combinational.
  - Inputs: x, y.
  - Outputs: next_x, next_y, done, result.
  - Implements one compare/subtract step including the zero and equal checks.
- The top-level gcd holds the registers, state machine and reset handling.

Test Plan:
- Coprime: rst low 5 cycles with xi=13, yi=7, then release, wait for rdy rising -> xo=1.
- Equal at max: xi=65535, yi=65535 -> rdy high on the 2nd edge after release; xo=65535.
- Zero operand: (0,7) -> xo=0. Also (7,0) -> 0 and (0,0) -> 0.
- Ordering symmetry: (42,18) -> xo=6 and (18,42) -> xo=6. rdy stays high and xo stays stable for 20 further cycles.
- Reset mid-run: start (65535,1), assert rst after 100 cycles with (12,8).
  - rdy stays 0 during reset.
  - xo=4 with a fresh rdy rising edge after release.
- Random: 100 random 16-bit pairs with both nonzero -> xo equals a reference GCD. Each run completes within 65540 cycles.
